// File: rtl/hzd_pkg.sv
// Shared types for the pipeline hazard controller.
//   fwd_sel_e   : EX operand forwarding mux select
//   hzd_state_e : load-use stall FSM state
//   lu_cnt_t    : remaining load-use bubble counter
package hzd_pkg;

   typedef enum logic [1:0] {
      FWD_RF    = 2'b00,
      FWD_MEMWB = 2'b01,
      FWD_EXMEM = 2'b10
   } fwd_sel_e;

   typedef enum logic {
      RUN      = 1'b0,
      LU_STALL = 1'b1
   } hzd_state_e;

   // Four bits cover the legal LOAD_STALL range of 1..15.
   localparam int LU_CNT_W = 4;
   typedef logic [LU_CNT_W-1:0] lu_cnt_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
//   master : the pipeline datapath (drives register/usage info, sees controls)
//   slave  : the hazard controller
// Inputs to the controller: ID/EX/MEM/WB register fields, write enables,
// dmem_busy, branch_taken, cnt_clr.
// Outputs from the controller: PC/IF-ID enables, bubble, flushes, freeze,
// forwarding selects and the two event counters.
interface pipe_hazard_ctrl_if #(
   parameter int RA_W  = 5,
   parameter int CNT_W = 32
);
   logic [RA_W-1:0]  ifid_rs1;
   logic [RA_W-1:0]  ifid_rs2;
   logic             ifid_uses_rs1;
   logic             ifid_uses_rs2;
   logic [RA_W-1:0]  idex_rs1;
   logic [RA_W-1:0]  idex_rs2;
   logic             idex_uses_rs2;
   logic             idex_mem_read;
   logic [RA_W-1:0]  idex_rd;
   logic             exmem_reg_write;
   logic             memwb_reg_write;
   logic [RA_W-1:0]  exmem_rd;
   logic [RA_W-1:0]  memwb_rd;
   logic             dmem_busy;
   logic             branch_taken;
   logic             cnt_clr;

   logic             pc_write;
   logic             ifid_write;
   logic             idex_bubble;
   logic             ifid_flush;
   logic             idex_flush;
   logic             pipe_freeze;
   logic [1:0]       forward_a;
   logic [1:0]       forward_b;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output ifid_rs1, ifid_rs2, ifid_uses_rs1, ifid_uses_rs2,
             idex_rs1, idex_rs2, idex_uses_rs2, idex_mem_read, idex_rd,
             exmem_reg_write, memwb_reg_write, exmem_rd, memwb_rd,
             dmem_busy, branch_taken, cnt_clr,
      input  pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush,
             pipe_freeze, forward_a, forward_b, stall_cnt, flush_cnt
   );

   modport slave (
      input  ifid_rs1, ifid_rs2, ifid_uses_rs1, ifid_uses_rs2,
             idex_rs1, idex_rs2, idex_uses_rs2, idex_mem_read, idex_rd,
             exmem_reg_write, memwb_reg_write, exmem_rd, memwb_rd,
             dmem_busy, branch_taken, cnt_clr,
      output pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush,
             pipe_freeze, forward_a, forward_b, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/fwd_sel.sv
// Single-operand forwarding comparator.
//   rs, uses           : source register of the EX operand and whether it is read
//   exmem_rd/exmem_we  : destination / write enable in MEM
//   memwb_rd/memwb_we  : destination / write enable in WB
//   sel                : FWD_EXMEM, FWD_MEMWB or FWD_RF
// The younger producer (EX/MEM) wins over MEM/WB; x0 never forwards.
module fwd_sel
   import hzd_pkg::*;
#(
   parameter int RA_W = 5
) (
   input  logic [RA_W-1:0] rs,
   input  logic            uses,
   input  logic [RA_W-1:0] exmem_rd,
   input  logic            exmem_we,
   input  logic [RA_W-1:0] memwb_rd,
   input  logic            memwb_we,
   output fwd_sel_e        sel
);

   always_comb begin
      sel = FWD_RF;
      if (uses) begin
         if (exmem_we && (exmem_rd != '0) && (exmem_rd == rs))
            sel = FWD_EXMEM;
         else if (memwb_we && (memwb_rd != '0) && (memwb_rd == rs))
            sel = FWD_MEMWB;
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Unified hazard controller for the RV32I 5-stage pipeline.
//   clk, rst_n : pipeline clock, asynchronous active-low reset
//   hz         : pipe_hazard_ctrl_if.slave bundle
//                in : ID/EX/MEM/WB register fields, dmem_busy, branch_taken, cnt_clr
//                out: pc_write, ifid_write, idex_bubble, ifid/idex_flush,
//                     pipe_freeze, forward_a/b, stall_cnt, flush_cnt
// Control and forwarding outputs are combinational; only the FSM state, the
// load-use bubble counter and the two event counters are registered.
// LOAD_STALL must lie in 1..15.
module pipe_hazard_ctrl
   import hzd_pkg::*;
#(
   parameter int RA_W       = 5,
   parameter int LOAD_STALL = 1,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   pipe_hazard_ctrl_if.slave hz
);

   localparam int NUM_OPS = 2;

   // ---------------------------------------------------------------- forwarding
   logic [NUM_OPS-1:0][RA_W-1:0] op_rs;
   logic [NUM_OPS-1:0]           op_uses;
   fwd_sel_e                     op_sel [NUM_OPS];

   // Operand A (rs1) is read by every instruction that reaches the EX mux.
   assign op_rs   = {hz.idex_rs2, hz.idex_rs1};
   assign op_uses = {hz.idex_uses_rs2, 1'b1};

   for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
      fwd_sel #(.RA_W(RA_W)) u_fwd (
         .rs       (op_rs[g]),
         .uses     (op_uses[g]),
         .exmem_rd (hz.exmem_rd),
         .exmem_we (hz.exmem_reg_write),
         .memwb_rd (hz.memwb_rd),
         .memwb_we (hz.memwb_reg_write),
         .sel      (op_sel[g])
      );
   end

   assign hz.forward_a = op_sel[0];
   assign hz.forward_b = op_sel[1];

   // ---------------------------------------------------------------- load-use
   logic load_use;

   assign load_use = hz.idex_mem_read && (hz.idex_rd != '0) &&
                     ((hz.ifid_uses_rs1 && (hz.idex_rd == hz.ifid_rs1)) ||
                      (hz.ifid_uses_rs2 && (hz.idex_rd == hz.ifid_rs2)));

   // ---------------------------------------------------------------- FSM
   hzd_state_e state_q, state_d;
   lu_cnt_t    lu_cnt_q, lu_cnt_d;

   logic pc_write, ifid_write, idex_bubble, flush, pipe_freeze;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= RUN;
         lu_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         lu_cnt_q <= lu_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      lu_cnt_d    = lu_cnt_q;
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      idex_bubble = 1'b0;
      flush       = 1'b0;
      pipe_freeze = 1'b0;

      if (hz.dmem_busy) begin
         // Whole pipe holds; a branch in EX is resolved again once memory is ready.
         pipe_freeze = 1'b1;
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
      end else if (hz.branch_taken) begin
         // The stalled consumer is on the wrong path, so drop what is left of the stall.
         flush    = 1'b1;
         state_d  = RUN;
         lu_cnt_d = '0;
      end else if (state_q == LU_STALL) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_bubble = 1'b1;
         if (lu_cnt_q <= lu_cnt_t'(1)) begin
            state_d  = RUN;
            lu_cnt_d = '0;
         end else begin
            lu_cnt_d = lu_cnt_q - lu_cnt_t'(1);
         end
      end else if (load_use) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_bubble = 1'b1;
         // This cycle is the first bubble; LU_STALL supplies the remainder.
         if (LOAD_STALL > 1) begin
            state_d  = LU_STALL;
            lu_cnt_d = lu_cnt_t'(LOAD_STALL - 1);
         end
      end
   end

   assign hz.pc_write    = pc_write;
   assign hz.ifid_write  = ifid_write;
   assign hz.idex_bubble = idex_bubble;
   assign hz.ifid_flush  = flush;
   assign hz.idex_flush  = flush;
   assign hz.pipe_freeze = pipe_freeze;

   // ---------------------------------------------------------------- counters
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (hz.cnt_clr) begin
         stall_cnt_d = '0;
         flush_cnt_d = '0;
      end else begin
         if (!pc_write && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
         if (flush && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign hz.stall_cnt = stall_cnt_q;
   assign hz.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (LOAD_STALL=3, CNT_W=4).
// Reference model: an integer count of outstanding bubbles plus two
// saturating integer counters, updated from the behavioural rules.
module tb_pipe_hazard_ctrl;

   localparam int RA_W = 5;
   localparam int LS   = 3;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic clk;
   logic rst_n;

   pipe_hazard_ctrl_if #(.RA_W(RA_W), .CNT_W(CW)) bus ();

   pipe_hazard_ctrl #(.RA_W(RA_W), .LOAD_STALL(LS), .CNT_W(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // model state
   int rem  = 0;   // bubbles still owed after the current cycle
   int scnt = 0;
   int fcnt = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [1:0] fwd(input int rs, input bit uses,
                                      input bit ew, input int erd,
                                      input bit mw, input int mrd);
      if (!uses)                         return 2'b00;
      if (ew && erd != 0 && erd == rs)   return 2'b10;
      if (mw && mrd != 0 && mrd == rs)   return 2'b01;
      return 2'b00;
   endfunction

   task automatic zero_in();
      bus.ifid_rs1 = '0; bus.ifid_rs2 = '0;
      bus.ifid_uses_rs1 = 0; bus.ifid_uses_rs2 = 0;
      bus.idex_rs1 = '0; bus.idex_rs2 = '0; bus.idex_uses_rs2 = 0;
      bus.idex_mem_read = 0; bus.idex_rd = '0;
      bus.exmem_reg_write = 0; bus.memwb_reg_write = 0;
      bus.exmem_rd = '0; bus.memwb_rd = '0;
      bus.dmem_busy = 0; bus.branch_taken = 0; bus.cnt_clr = 0;
   endtask

   // load in EX writes x4, ID instruction reads rs1=x4
   task automatic set_lu();
      bus.idex_mem_read = 1; bus.idex_rd = 5'd4;
      bus.ifid_rs1 = 5'd4; bus.ifid_uses_rs1 = 1;
   endtask

   // One clock: check combinational outputs and counters at the negedge,
   // then advance the model at the posedge.
   task automatic cyc();
      bit lu, e_pc, e_bub, e_fl, e_frz;
      logic [1:0] e_fa, e_fb;
      @(negedge clk);
      lu = bus.idex_mem_read && bus.idex_rd != 0 &&
           ((bus.ifid_uses_rs1 && bus.idex_rd == bus.ifid_rs1) ||
            (bus.ifid_uses_rs2 && bus.idex_rd == bus.ifid_rs2));
      e_pc = 1; e_bub = 0; e_fl = 0; e_frz = 0;
      if (bus.dmem_busy)          begin e_pc = 0; e_frz = 1; end
      else if (bus.branch_taken)  e_fl = 1;
      else if (rem > 0 || lu)     begin e_pc = 0; e_bub = 1; end
      e_fa = fwd(int'(bus.idex_rs1), 1'b1, bus.exmem_reg_write, int'(bus.exmem_rd),
                 bus.memwb_reg_write, int'(bus.memwb_rd));
      e_fb = fwd(int'(bus.idex_rs2), bus.idex_uses_rs2, bus.exmem_reg_write,
                 int'(bus.exmem_rd), bus.memwb_reg_write, int'(bus.memwb_rd));
      chk("pc_write",    32'(bus.pc_write),    32'(e_pc));
      chk("ifid_write",  32'(bus.ifid_write),  32'(e_pc));
      chk("idex_bubble", 32'(bus.idex_bubble), 32'(e_bub));
      chk("ifid_flush",  32'(bus.ifid_flush),  32'(e_fl));
      chk("idex_flush",  32'(bus.idex_flush),  32'(e_fl));
      chk("pipe_freeze", 32'(bus.pipe_freeze), 32'(e_frz));
      chk("forward_a",   32'(bus.forward_a),   32'(e_fa));
      chk("forward_b",   32'(bus.forward_b),   32'(e_fb));
      chk("stall_cnt",   32'(bus.stall_cnt),   32'(scnt));
      chk("flush_cnt",   32'(bus.flush_cnt),   32'(fcnt));
      @(posedge clk);
      if (!rst_n) begin
         rem = 0; scnt = 0; fcnt = 0;
      end else begin
         if (bus.cnt_clr) begin
            scnt = 0; fcnt = 0;
         end else begin
            if (!e_pc && scnt < CMAX) scnt++;
            if (e_fl && fcnt < CMAX)  fcnt++;
         end
         if (!bus.dmem_busy) begin
            if (bus.branch_taken) rem = 0;
            else if (rem > 0)     rem--;
            else if (lu)          rem = LS - 1;
         end
      end
      #1;
   endtask

   task automatic clr_cnt();
      zero_in();
      bus.cnt_clr = 1;
      cyc();
      bus.cnt_clr = 0;
   endtask

   initial begin
      rst_n = 0;
      zero_in();
      #2;
      chk("rst_pc_write",  32'(bus.pc_write),    32'd1);
      chk("rst_bubble",    32'(bus.idex_bubble), 32'd0);
      chk("rst_stall_cnt", 32'(bus.stall_cnt),   32'd0);
      cyc();
      rst_n = 1;
      cyc();

      // forwarding priority and rs2 qualification
      bus.exmem_reg_write = 1; bus.exmem_rd = 5'd5;
      bus.memwb_reg_write = 1; bus.memwb_rd = 5'd5;
      bus.idex_rs1 = 5'd5;
      #1 chk("fwd_a_exmem", 32'(bus.forward_a), 32'd2);
      bus.exmem_rd = 5'd0;
      #1 chk("fwd_a_memwb", 32'(bus.forward_a), 32'd1);
      bus.idex_uses_rs2 = 0; bus.idex_rs2 = 5'd7; bus.exmem_rd = 5'd7;
      #1 chk("fwd_b_unused", 32'(bus.forward_b), 32'd0);
      bus.idex_uses_rs2 = 1;
      #1 chk("fwd_b_used", 32'(bus.forward_b), 32'd2);
      cyc();

      // plain 3-cycle load-use stall
      clr_cnt();
      set_lu();
      #1 chk("lu_first_bubble", 32'(bus.idex_bubble), 32'd1);
      cyc();
      zero_in();
      cyc(); cyc();
      #1 chk("lu_release", 32'(bus.pc_write), 32'd1);
      cyc();
      chk("lu3_stall_cnt", 32'(bus.stall_cnt), 32'd3);

      // dmem_busy for 2 cycles from the 2nd stall cycle
      clr_cnt();
      set_lu();
      cyc();
      zero_in();
      bus.dmem_busy = 1;
      #1 chk("busy_freeze", 32'(bus.pipe_freeze), 32'd1);
      cyc(); cyc();
      bus.dmem_busy = 0;
      cyc(); cyc();
      cyc();
      chk("busy_stall_cnt", 32'(bus.stall_cnt), 32'd5);

      // branch aborts a pending load-use stall
      clr_cnt();
      set_lu();
      cyc();
      zero_in();
      bus.branch_taken = 1;
      #1 chk("br_flush", 32'(bus.ifid_flush), 32'd1);
      chk("br_pc_write", 32'(bus.pc_write), 32'd1);
      cyc();
      bus.branch_taken = 0;
      #1 chk("br_run_next", 32'(bus.pc_write), 32'd1);
      cyc();
      chk("br_flush_cnt", 32'(bus.flush_cnt), 32'd1);

      // saturation and asynchronous reset mid-stall
      clr_cnt();
      set_lu();
      for (int i = 0; i < 20; i++) cyc();
      chk("sat_stall_cnt", 32'(bus.stall_cnt), 32'(CMAX));
      zero_in();
      #1 rst_n = 0;
      rem = 0; scnt = 0; fcnt = 0;
      #1;
      chk("arst_pc_write",  32'(bus.pc_write),    32'd1);
      chk("arst_bubble",    32'(bus.idex_bubble), 32'd0);
      chk("arst_stall_cnt", 32'(bus.stall_cnt),   32'd0);
      rst_n = 1;
      cyc(); cyc();

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         bus.ifid_rs1        = 5'($urandom_range(0, 3));
         bus.ifid_rs2        = 5'($urandom_range(0, 3));
         bus.ifid_uses_rs1   = ($urandom_range(0, 3) != 0);
         bus.ifid_uses_rs2   = ($urandom_range(0, 3) != 0);
         bus.idex_rs1        = 5'($urandom_range(0, 3));
         bus.idex_rs2        = 5'($urandom_range(0, 3));
         bus.idex_uses_rs2   = $urandom_range(0, 1) == 1;
         bus.idex_mem_read   = ($urandom_range(0, 2) == 0);
         bus.idex_rd         = 5'($urandom_range(0, 3));
         bus.exmem_reg_write = $urandom_range(0, 1) == 1;
         bus.memwb_reg_write = $urandom_range(0, 1) == 1;
         bus.exmem_rd        = 5'($urandom_range(0, 3));
         bus.memwb_rd        = 5'($urandom_range(0, 3));
         bus.dmem_busy       = ($urandom_range(0, 5) == 0);
         bus.branch_taken    = ($urandom_range(0, 7) == 0);
         bus.cnt_clr         = ($urandom_range(0, 59) == 0);
         cyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
